capture_scheduler: RTL and testbench

- Sits behind the sticky event-capture stage and sequences its serviced flags to one downstream consumer.
- Latches single-cycle event pulses on N channels as per-channel pending flags, with a saturating event count per channel.
- Picks one pending channel at a time using round-robin order and offers it over a valid/ready handshake.
- On selection it clears that channel's flag, so each channel is cleared individually rather than by one global clear.

---
 rtl/capture_scheduler_pkg.sv | 23 ++
 rtl/capture_scheduler_rr_pick.sv | 39 +++
 rtl/capture_scheduler.sv | 112 +++++++++++
 tb/tb_capture_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_scheduler_pkg.sv
// capture_scheduler_pkg: shared definitions for the capture scheduler slice.
//   state_t   - scheduler FSM states (ST_IDLE, ST_OFFER)
//   idx_width - channel index width, clog2(n) with a floor of 1
//   sat_inc   - saturating increment of a value held in w bits (w <= 32)
package capture_scheduler_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                            input int unsigned w);
        logic [31:0] top;
        top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (inc && v != top) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/capture_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req  [N]     - request vector
//   last [IDX_W] - most recently granted channel; search starts at last+1
//   any          - at least one request is set
//   idx  [IDX_W] - first set request in order last+1 .. N-1, 0 .. last
module rr_pick
    import capture_scheduler_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic           found;

    // Lower copy is masked to channels above last; the unmasked upper copy
    // supplies the wrap-around part, so a plain lowest-bit search suffices.
    always_comb begin
        dbl = {req, req};
        for (int unsigned j = 0; j < N; j++) begin
            if (j <= 32'(last)) dbl[j] = 1'b0;
        end
        any   = |req;
        idx   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < 2 * N; j++) begin
            if (!found && dbl[j]) begin
                found = 1'b1;
                idx   = (j >= N) ? IDX_W'(j - N) : IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/capture_scheduler.sv
// capture_scheduler: latches event pulses as per-channel pending flags with
// saturating coalesce counts, and offers one channel at a time in
// round-robin order over a valid/ready handshake.
//   clk, r (async, active-high)  - clock and reset
//   en                           - allow new selections
//   clr                          - synchronous flush of pending state and offer
//   s [N]                        - single-cycle event pulses
//   pending [N]                  - registered pending flags
//   out_valid/out_ready          - offer handshake
//   out_idx, out_cnt, out_sat    - offered channel, coalesced count, overflow flag
module capture_scheduler
    import capture_scheduler_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     s,
    output logic [N-1:0]     pending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt [N];
    logic [N-1:0]     sat;
    logic [IDX_W-1:0] last;

    logic [N-1:0]     cand;
    logic [N-1:0]     hit;
    logic [N-1:0]     take_oh;
    logic [CNT_W-1:0] cnt_inc [N];
    logic             accept;
    logic             take;
    logic             any;
    logic [IDX_W-1:0] k;

    assign cand   = pending | s;
    assign accept = (state == ST_OFFER) && out_ready;
    assign take   = en && any && ((state == ST_IDLE) || accept);

    rr_pick #(.N(N)) u_pick (
        .req  (cand),
        .last (last),
        .any  (any),
        .idx  (k)
    );

    // cnt_inc/hit already include this cycle's pulse, so a take-cycle event
    // on the chosen channel lands in the snapshot and nowhere else.
    always_comb begin
        take_oh = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_inc[i] = CNT_W'(sat_inc(32'(cnt[i]), s[i], CNT_W));
            hit[i]     = s[i] && (cnt[i] == CNT_MAX);
        end
        if (take) take_oh[k] = 1'b1;
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            pending   <= '0;
            sat       <= '0;
            for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
            last      <= IDX_W'(N - 1);
            out_idx   <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
        end else if (clr) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            pending   <= '0;
            sat       <= '0;
            for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (take_oh[i]) begin
                    pending[i] <= 1'b0;
                    cnt[i]     <= '0;
                    sat[i]     <= 1'b0;
                end else if (s[i]) begin
                    pending[i] <= 1'b1;
                    cnt[i]     <= cnt_inc[i];
                    if (hit[i]) sat[i] <= 1'b1;
                end
            end
            if (take) begin
                state     <= ST_OFFER;
                out_valid <= 1'b1;
                out_idx   <= k;
                out_cnt   <= cnt_inc[k];
                out_sat   <= sat[k] | hit[k];
                last      <= k;
            end else if (accept) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_scheduler.sv
// tb_capture_scheduler: drives a default instance (CNT_W=8) and a CNT_W=2
// instance with the same directed stimulus, compares both against a
// behavioural model every cycle, and pins key results with literal values.
module tb_capture_scheduler;

    logic       clk;
    logic       r;
    logic       en;
    logic       clr;
    logic [3:0] s;
    logic       out_ready;

    logic [3:0] p0, p1;
    logic       v0, v1;
    logic [1:0] i0, i1;
    logic [7:0] c0;
    logic [1:0] c1;
    logic       sa0, sa1;

    int checks   = 0;
    int failures = 0;

    capture_scheduler dut (
        .clk(clk), .r(r), .en(en), .clr(clr), .s(s), .pending(p0),
        .out_valid(v0), .out_ready(out_ready), .out_idx(i0), .out_cnt(c0), .out_sat(sa0)
    );

    capture_scheduler #(.N(4), .CNT_W(2)) dut2 (
        .clk(clk), .r(r), .en(en), .clr(clr), .s(s), .pending(p1),
        .out_valid(v1), .out_ready(out_ready), .out_idx(i1), .out_cnt(c1), .out_sat(sa1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model (index 0: CNT_W=8, 1: CNT_W=2)
    bit [3:0] mpend [2];
    bit [3:0] msat  [2];
    int       mcnt  [2][4];
    int       mlast [2];
    bit       mv    [2];
    int       midx  [2];
    int       mocnt [2];
    bit       mosat [2];
    int       mmax  [2] = '{255, 3};

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                mpend[d] = '0;
                msat[d]  = '0;
                for (int i = 0; i < 4; i++) mcnt[d][i] = 0;
                mlast[d] = 3;
                mv[d]    = 1'b0;
                midx[d]  = 0;
                mocnt[d] = 0;
                mosat[d] = 1'b0;
            end else if (clr) begin
                mpend[d] = '0;
                msat[d]  = '0;
                for (int i = 0; i < 4; i++) mcnt[d][i] = 0;
                mv[d]    = 1'b0;
            end else begin
                int k;
                k = -1;
                if (en && (!mv[d] || out_ready)) begin
                    for (int o = 1; o <= 4; o++) begin
                        int c;
                        c = (mlast[d] + o) % 4;
                        if (k < 0 && (mpend[d][c] || s[c])) k = c;
                    end
                end
                if (k >= 0) begin
                    mocnt[d] = (mcnt[d][k] + int'(s[k]) > mmax[d]) ? mmax[d]
                                                                   : mcnt[d][k] + int'(s[k]);
                    mosat[d] = msat[d][k] || (s[k] && mcnt[d][k] == mmax[d]);
                    midx[d]  = k;
                    mv[d]    = 1'b1;
                    mlast[d] = k;
                end else if (mv[d] && out_ready) begin
                    mv[d] = 1'b0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (i == k) begin
                        mpend[d][i] = 1'b0;
                        msat[d][i]  = 1'b0;
                        mcnt[d][i]  = 0;
                    end else if (s[i]) begin
                        mpend[d][i] = 1'b1;
                        if (mcnt[d][i] == mmax[d]) msat[d][i] = 1'b1;
                        else mcnt[d][i] = mcnt[d][i] + 1;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge r);
        model_step();
    end

    // ---------------- checking
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input int d, input logic v, input logic [3:0] p,
                       input logic [1:0] idx, input int cnt, input logic sat);
        chk($sformatf("model d%0d out_valid", d), v, mv[d]);
        chk($sformatf("model d%0d pending", d), p, mpend[d]);
        if (mv[d]) begin
            chk($sformatf("model d%0d out_idx", d), idx, midx[d]);
            chk($sformatf("model d%0d out_cnt", d), cnt, mocnt[d]);
            chk($sformatf("model d%0d out_sat", d), sat, mosat[d]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!r) begin
            cmp(0, v0, p0, i0, int'(c0), sa0);
            cmp(1, v1, p1, i1, int'(c1), sa1);
        end
    end

    task automatic step(input logic [3:0] sv);
        s = sv;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus
    initial begin
        r = 1'b1; en = 1'b0; clr = 1'b0; s = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 r = 1'b0;
        chk("reset valid", v0, 0);
        chk("reset pending", p0, 0);
        chk("reset cnt", c0, 0);

        // round-robin over 1011, then wrap restarts at channel 0
        en = 1'b1; out_ready = 1'b1;
        step(4'b1011);
        chk("rr1 idx", i0, 0); chk("rr1 cnt", c0, 1); chk("rr1 pending", p0, 4'b1010);
        step(4'b0000);
        chk("rr2 idx", i0, 1);
        step(4'b0000);
        chk("rr3 idx", i0, 3); chk("rr3 cnt", c0, 1);
        step(4'b0000);
        chk("rr end valid", v0, 0);
        step(4'b0001);
        chk("rr wrap valid", v0, 1); chk("rr wrap idx", i0, 0);
        step(4'b0000);
        chk("rr wrap done", v0, 0);

        // coalescing on the offered channel
        out_ready = 1'b0;
        step(4'b0010);
        chk("coal first idx", i0, 1); chk("coal first cnt", c0, 1);
        repeat (3) step(4'b0010);
        chk("coal hold cnt", c0, 1); chk("coal hold pending", p0, 4'b0010);
        out_ready = 1'b1;
        step(4'b0000);
        chk("coal idx", i0, 1); chk("coal cnt", c0, 3); chk("coal valid", v0, 1);
        step(4'b0000);
        chk("coal done", v0, 0);

        // saturation (CNT_W=2 instance) with selection disabled
        en = 1'b0;
        repeat (5) step(4'b0100);
        chk("sat idle valid", v1, 0); chk("sat pending", p1, 4'b0100);
        en = 1'b1;
        step(4'b0000);
        chk("sat idx", i1, 2); chk("sat cnt", c1, 3); chk("sat flag", sa1, 1);
        chk("wide cnt", c0, 5); chk("wide flag", sa0, 0);
        step(4'b0100);
        chk("sat next idx", i1, 2); chk("sat next cnt", c1, 1); chk("sat next flag", sa1, 0);
        step(4'b0000);
        chk("sat done", v1, 0);

        // event on the chosen channel in the take cycle
        en = 1'b0;
        step(4'b0001);
        step(4'b0001);
        en = 1'b1;
        step(4'b0001);
        chk("fold idx", i0, 0); chk("fold cnt", c0, 3); chk("fold pending", p0, 0);
        step(4'b0000);
        chk("fold done", v0, 0);

        // clr during an offer discards everything including its own cycle's event
        out_ready = 1'b0;
        step(4'b0100);
        chk("clr offer idx", i0, 2);
        step(4'b1000);
        chk("clr pre pending", p0, 4'b1000);
        clr = 1'b1;
        step(4'b0001);
        chk("clr valid", v0, 0); chk("clr pending", p0, 0);
        clr = 1'b0;
        step(4'b0000);
        chk("clr discard valid", v0, 0); chk("clr discard pending", p0, 0);
        step(4'b1001);
        chk("clr keeps last", i0, 3);
        out_ready = 1'b1;
        step(4'b0000);
        chk("post clr idx", i0, 0);
        step(4'b0000);
        chk("post clr done", v0, 0);

        // asynchronous reset mid-offer
        out_ready = 1'b0;
        step(4'b0100);
        chk("rst offer idx", i0, 2); chk("rst offer cnt", c0, 1);
        step(4'b1000);
        chk("rst pre pending", p0, 4'b1000);
        #2 r = 1'b1;
        #1;
        chk("async valid", v0, 0); chk("async pending", p0, 0);
        chk("async cnt", c0, 0); chk("async valid d2", v1, 0);
        @(posedge clk);
        #1 r = 1'b0;
        step(4'b0000);
        chk("after reset valid", v0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
